// File: rtl/mc_ctrl_fsm_hs_pkg.sv
// mc_pkg: state encoding, opcodes and datapath select codes shared by the mc_ctrl_fsm_hs slice
package mc_pkg;
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, RWB,
    BRANCH, JUMP, ADDI_EX, ADDI_WB, FAULT
  } state_t;
  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000;
  localparam logic [1:0] ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_FUNCT = 2'b10;
  localparam logic [1:0] PC_ALU = 2'b00, PC_ALUOUT = 2'b01, PC_JUMP = 2'b10;
  localparam logic [1:0] SRCB_REG = 2'b00, SRCB_FOUR = 2'b01, SRCB_IMM = 2'b10, SRCB_IMM_SH = 2'b11;
  function automatic logic is_mem_state(state_t s);
    return s == FETCH || s == MEMRD || s == MEMWR;
  endfunction
endpackage

// File: rtl/mc_ctrl_fsm_hs_wait_timer.sv
// mc_wait_timer: counts memory wait cycles and flags the wait that hits the timeout limit
// ports: clk, reset (sync, active-high), clr (restart count), inc (one wait cycle),
//        expired (this wait cycle is the MEM_TIMEOUT-th one)
module mc_wait_timer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int TMR_W = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic expired
);
  logic [TMR_W-1:0] cnt;
  always_ff @(posedge clk)
    cnt <= (reset || clr) ? '0 : inc ? cnt + 1'b1 : cnt;
  assign expired = inc && cnt == TMR_W'(MEM_TIMEOUT - 1);
endmodule

// File: rtl/mc_ctrl_fsm_hs.sv
// mc_ctrl_fsm_hs: multicycle MIPS-subset control FSM with mem_ready handshake, watchdog and fault state
// ports: clk, reset (sync, active-high), opcode (IR[31:26]), zero (ALU flag), mem_ready (access done),
//        datapath controls IorD..PCWrite_F, fault (sticky), state_o (current state),
//        cyc_cnt/instr_cnt perf counters present only when MC_PERF_CNT_EN is defined
module mc_ctrl_fsm_hs
  import mc_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int TMR_W = 5
`ifdef MC_PERF_CNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemtoReg,
  output logic             IRWrite,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic             PCWrite_F,
  output logic             fault,
  output logic [3:0]       state_o
`ifdef MC_PERF_CNT_EN
  , output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] instr_cnt
`endif
);
  state_t state, next;
  logic wait_cyc, expired;
  // the timer is held clear whenever no access is stalling, so every access starts from zero
  assign wait_cyc = is_mem_state(state) && !mem_ready;
  mc_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT), .TMR_W(TMR_W)) u_timer (
    .clk(clk), .reset(reset), .clr(!wait_cyc), .inc(wait_cyc), .expired(expired)
  );
  always_comb begin
    next = FAULT;
    case (state)
      FETCH:   next = mem_ready ? DECODE : expired ? FAULT : FETCH;
      DECODE:  next = (opcode == OP_LW || opcode == OP_SW) ? MEMADR :
                      opcode == OP_R ? EXEC : opcode == OP_BEQ ? BRANCH :
                      opcode == OP_J ? JUMP : opcode == OP_ADDI ? ADDI_EX : FAULT;
      MEMADR:  next = opcode == OP_LW ? MEMRD : MEMWR;
      MEMRD:   next = mem_ready ? MEMWB : expired ? FAULT : MEMRD;
      MEMWR:   next = mem_ready ? FETCH : expired ? FAULT : MEMWR;
      EXEC:    next = RWB;
      ADDI_EX: next = ADDI_WB;
      MEMWB, RWB, BRANCH, JUMP, ADDI_WB: next = FETCH;
      default: next = FAULT;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= FETCH;
`ifdef MC_PERF_CNT_EN
      cyc_cnt <= '0;
      instr_cnt <= '0;
`endif
    end else begin
      state <= next;
`ifdef MC_PERF_CNT_EN
      if (state != FAULT) cyc_cnt <= cyc_cnt + 1'b1;
      if (next == FETCH && state != FETCH) instr_cnt <= instr_cnt + 1'b1;
`endif
    end
  always_comb begin
    {IorD, MemRead, MemWrite, MemtoReg, IRWrite, RegDst, RegWrite, ALUSrcA, PCWrite_F} = '0;
    ALUSrcB = SRCB_REG;
    ALUOp = ALU_ADD;
    PCSource = PC_ALU;
    case (state)
      FETCH:   begin MemRead = 1'b1; ALUSrcB = SRCB_FOUR; IRWrite = mem_ready; PCWrite_F = mem_ready; end
      DECODE:  ALUSrcB = SRCB_IMM_SH;
      MEMADR:  begin ALUSrcA = 1'b1; ALUSrcB = SRCB_IMM; end
      MEMRD:   begin MemRead = 1'b1; IorD = 1'b1; end
      MEMWB:   begin MemtoReg = 1'b1; RegWrite = 1'b1; end
      MEMWR:   begin MemWrite = 1'b1; IorD = 1'b1; end
      EXEC:    begin ALUSrcA = 1'b1; ALUOp = ALU_FUNCT; end
      RWB:     begin RegDst = 1'b1; RegWrite = 1'b1; end
      BRANCH:  begin ALUSrcA = 1'b1; ALUOp = ALU_SUB; PCSource = PC_ALUOUT; PCWrite_F = zero; end
      JUMP:    begin PCSource = PC_JUMP; PCWrite_F = 1'b1; end
      ADDI_EX: begin ALUSrcA = 1'b1; ALUSrcB = SRCB_IMM; end
      ADDI_WB: RegWrite = 1'b1;
      default: ;
    endcase
  end
  assign fault = state == FAULT;
  assign state_o = state;
endmodule

// File: tb/tb_mc_ctrl_fsm_hs.sv
// tb_mc_ctrl_fsm_hs: directed vector table, handshake corner sequences and a randomized queue-model check
module tb_mc_ctrl_fsm_hs;
  import mc_pkg::*;
  localparam int TO = 16;
  localparam logic [5:0] L_R = 6'b000000, L_LW = 6'b100011, L_SW = 6'b101011;
  localparam logic [5:0] L_BEQ = 6'b000100, L_J = 6'b000010, L_ADDI = 6'b001000, L_BAD = 6'b111111;
  logic clk = 1'b0;
  logic reset = 1'b1, zero = 1'b0, mem_ready = 1'b0;
  logic [5:0] opcode = 6'b0;
  logic IorD, MemRead, MemWrite, MemtoReg, IRWrite, RegDst, RegWrite, ALUSrcA, PCWrite_F, fault;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] state_o;
`ifdef MC_PERF_CNT_EN
  logic [31:0] cyc_cnt, instr_cnt;
`endif
  always #5 clk = ~clk;
  mc_ctrl_fsm_hs dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg), .IRWrite(IRWrite),
    .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .PCWrite_F(PCWrite_F), .fault(fault), .state_o(state_o)
`ifdef MC_PERF_CNT_EN
    , .cyc_cnt(cyc_cnt), .instr_cnt(instr_cnt)
`endif
  );
  int n_chk = 0, n_pass = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask
  // inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge
  task automatic go(input logic r, input logic [5:0] o, input logic m, input logic z);
    @(posedge clk);
    #1;
    reset = r; opcode = o; mem_ready = m; zero = z;
    @(negedge clk);
  endtask
  typedef struct { logic [5:0] op; logic mr; logic z; state_t st; logic [6:0] strb; logic [1:0] pcs; logic flt; } vec_t;
  vec_t tbl[$];
  task automatic add(input logic [5:0] op, input logic mr, input logic z, input state_t st,
                     input logic [6:0] strb, input logic [1:0] pcs, input logic flt);
    tbl.push_back('{op, mr, z, st, strb, pcs, flt});
  endtask
  typedef struct packed {
    logic iord, mrd, mwr, m2r, irw, rdst, rw, asa;
    logic [1:0] asb, aop, pcs;
    logic pcw, flt;
    logic [3:0] st;
  } ctl_t;
  function automatic ctl_t act_ctl();
    return {IorD, MemRead, MemWrite, MemtoReg, IRWrite, RegDst, RegWrite, ALUSrcA,
            ALUSrcB, ALUOp, PCSource, PCWrite_F, fault, state_o};
  endfunction
  function automatic ctl_t exp_ctl(input state_t s, input logic mr, input logic z);
    ctl_t e;
    e = '0;
    e.st = s;
    case (s)
      FETCH:   begin e.mrd = 1; e.asb = 2'b01; e.irw = mr; e.pcw = mr; end
      DECODE:  e.asb = 2'b11;
      MEMADR:  begin e.asa = 1; e.asb = 2'b10; end
      MEMRD:   begin e.mrd = 1; e.iord = 1; end
      MEMWB:   begin e.m2r = 1; e.rw = 1; end
      MEMWR:   begin e.mwr = 1; e.iord = 1; end
      EXEC:    begin e.asa = 1; e.aop = 2'b10; end
      RWB:     begin e.rdst = 1; e.rw = 1; end
      BRANCH:  begin e.asa = 1; e.aop = 2'b01; e.pcs = 2'b01; e.pcw = z; end
      JUMP:    begin e.pcs = 2'b10; e.pcw = 1; end
      ADDI_EX: begin e.asa = 1; e.asb = 2'b10; end
      ADDI_WB: e.rw = 1;
      FAULT:   e.flt = 1;
      default: ;
    endcase
    return e;
  endfunction
  // reference model: a queue of pending instruction steps, refilled from the opcode at decode
  state_t q[$];
  int waits, m_cyc, m_ins;
  bit mfault;
  function void m_reset();
    q.delete();
    q.push_back(FETCH);
    waits = 0; mfault = 0; m_cyc = 0; m_ins = 0;
  endfunction
  function void m_step(input logic r, input logic [5:0] op, input logic mr);
    state_t cur;
    if (r) begin m_reset(); return; end
    if (mfault) return;
    cur = q[0];
    m_cyc++;
    if (cur == FETCH || cur == MEMRD || cur == MEMWR) begin
      if (!mr) begin
        waits++;
        if (waits == TO) mfault = 1;
        return;
      end
      waits = 0;
    end
    void'(q.pop_front());
    if (cur == FETCH) q.push_back(DECODE);
    if (cur == DECODE)
      case (op)
        L_LW:   begin q.push_back(MEMADR); q.push_back(MEMRD); q.push_back(MEMWB); end
        L_SW:   begin q.push_back(MEMADR); q.push_back(MEMWR); end
        L_R:    begin q.push_back(EXEC); q.push_back(RWB); end
        L_BEQ:  q.push_back(BRANCH);
        L_J:    q.push_back(JUMP);
        L_ADDI: begin q.push_back(ADDI_EX); q.push_back(ADDI_WB); end
        default: mfault = 1;
      endcase
    if (q.size() == 0 && !mfault) begin q.push_back(FETCH); m_ins++; end
  endfunction
  logic [5:0] ops [6];
  logic [5:0] r_op;
  logic r_rst, r_mr, r_z, stall;
  state_t cur;
  int f_cnt, k;
  initial begin
    ops[0] = L_R; ops[1] = L_LW; ops[2] = L_SW; ops[3] = L_BEQ; ops[4] = L_J; ops[5] = L_ADDI;
    // LW with three wait cycles per access
    add(L_LW, 0, 0, FETCH, 7'b0000100, 2'b00, 0);
    add(L_LW, 0, 0, FETCH, 7'b0000100, 2'b00, 0);
    add(L_LW, 0, 0, FETCH, 7'b0000100, 2'b00, 0);
    add(L_LW, 1, 0, FETCH, 7'b1100100, 2'b00, 0);
    add(L_LW, 1, 1, DECODE, 7'b0000000, 2'b00, 0);
    add(L_LW, 1, 1, MEMADR, 7'b0000000, 2'b00, 0);
    add(L_LW, 0, 0, MEMRD, 7'b0000100, 2'b00, 0);
    add(L_LW, 0, 0, MEMRD, 7'b0000100, 2'b00, 0);
    add(L_LW, 0, 0, MEMRD, 7'b0000100, 2'b00, 0);
    add(L_LW, 1, 0, MEMRD, 7'b0000100, 2'b00, 0);
    add(L_LW, 1, 1, MEMWB, 7'b0010010, 2'b00, 0);
    // BEQ taken then not taken
    add(L_BEQ, 1, 0, FETCH, 7'b1100100, 2'b00, 0);
    add(L_BEQ, 1, 1, DECODE, 7'b0000000, 2'b00, 0);
    add(L_BEQ, 1, 1, BRANCH, 7'b0100000, 2'b01, 0);
    add(L_BEQ, 1, 0, FETCH, 7'b1100100, 2'b00, 0);
    add(L_BEQ, 1, 0, DECODE, 7'b0000000, 2'b00, 0);
    add(L_BEQ, 1, 0, BRANCH, 7'b0000000, 2'b01, 0);
    // R, ADDI, J with no waits
    add(L_R, 1, 1, FETCH, 7'b1100100, 2'b00, 0);
    add(L_R, 1, 1, DECODE, 7'b0000000, 2'b00, 0);
    add(L_R, 1, 1, EXEC, 7'b0000000, 2'b00, 0);
    add(L_R, 1, 1, RWB, 7'b0010001, 2'b00, 0);
    add(L_ADDI, 1, 1, FETCH, 7'b1100100, 2'b00, 0);
    add(L_ADDI, 1, 1, DECODE, 7'b0000000, 2'b00, 0);
    add(L_ADDI, 1, 1, ADDI_EX, 7'b0000000, 2'b00, 0);
    add(L_ADDI, 1, 1, ADDI_WB, 7'b0010000, 2'b00, 0);
    add(L_J, 1, 1, FETCH, 7'b1100100, 2'b00, 0);
    add(L_J, 1, 1, DECODE, 7'b0000000, 2'b00, 0);
    add(L_J, 1, 1, JUMP, 7'b0100000, 2'b10, 0);
    // illegal opcode
    add(L_BAD, 1, 1, FETCH, 7'b1100100, 2'b00, 0);
    add(L_BAD, 1, 1, DECODE, 7'b0000000, 2'b00, 0);
    add(L_BAD, 1, 1, FAULT, 7'b0000000, 2'b00, 1);
    add(L_BAD, 1, 1, FAULT, 7'b0000000, 2'b00, 1);
    go(1, L_R, 0, 0);
    go(1, L_R, 0, 0);
    for (int i = 0; i < tbl.size(); i++) begin
      go(0, tbl[i].op, tbl[i].mr, tbl[i].z);
      chk($sformatf("vec[%0d]", i),
          {state_o, IRWrite, PCWrite_F, RegWrite, MemWrite, MemRead, MemtoReg, RegDst, PCSource, fault},
          {tbl[i].st, tbl[i].strb, tbl[i].pcs, tbl[i].flt});
    end
    // SW stalled forever: MemWrite through every wait, then FAULT until reset
    go(1, L_SW, 1, 0);
    go(0, L_SW, 1, 0);
    go(0, L_SW, 1, 0);
    go(0, L_SW, 1, 0);
    for (int i = 0; i < TO; i++) begin
      go(0, L_SW, 0, 0);
      chk("to_memwr", {state_o, MemWrite, fault}, {MEMWR, 1'b1, 1'b0});
    end
    go(0, L_SW, 0, 0);
    chk("to_fault", {state_o, MemWrite, fault}, {FAULT, 1'b0, 1'b1});
    go(0, L_SW, 1, 1);
    go(0, L_SW, 1, 1);
    chk("fault_sticky", {state_o, fault, PCWrite_F, MemRead}, {FAULT, 1'b1, 1'b0, 1'b0});
    go(1, L_SW, 1, 0);
    go(0, L_SW, 0, 0);
    chk("fault_reset", {state_o, fault}, {FETCH, 1'b0});
    // LW whose ready arrives on the limit cycle completes normally
    go(1, L_LW, 1, 0);
    go(0, L_LW, 1, 0);
    go(0, L_LW, 1, 0);
    go(0, L_LW, 1, 0);
    for (int i = 0; i < TO - 1; i++) go(0, L_LW, 0, 0);
    go(0, L_LW, 1, 0);
    chk("lim_memrd", {state_o, MemRead, fault}, {MEMRD, 1'b1, 1'b0});
    go(0, L_LW, 1, 0);
    chk("lim_memwb", {state_o, RegWrite, fault}, {MEMWB, 1'b1, 1'b0});
`ifdef MC_PERF_CNT_EN
    go(1, L_R, 1, 0);
    for (int i = 0; i < 11; i++) go(0, i < 4 ? L_R : i < 8 ? L_ADDI : L_J, 1, 0);
    go(0, L_LW, 1, 0);
    chk("perf_cnt", {cyc_cnt, instr_cnt}, {32'd11, 32'd3});
    go(0, L_LW, 1, 0);
    go(0, L_LW, 1, 0);
    go(0, L_LW, 0, 0);
    go(1, L_LW, 0, 0);
    go(0, L_LW, 0, 0);
    chk("perf_reset", {cyc_cnt, instr_cnt, 28'd0, state_o}, {32'd0, 32'd0, 28'd0, FETCH});
`endif
    // randomized run against the queue model
    go(1, L_R, 1, 0);
    m_reset();
    f_cnt = 0;
    stall = 0;
    r_op = L_R;
    for (int c = 0; c < 3000; c++) begin
      cur = mfault ? FAULT : q[0];
      if (cur == FETCH) begin
        k = $urandom_range(0, 19);
        r_op = k == 0 ? 6'($urandom) : ops[k % 6];
      end
      if (cur == DECODE) stall = $urandom_range(0, 5) == 0;
      r_mr = stall ? $urandom_range(0, 15) == 0 : $urandom_range(0, 3) != 0;
      r_z = 1'($urandom);
      r_rst = f_cnt > 2 || $urandom_range(0, 299) == 0;
      go(r_rst, r_op, r_mr, r_z);
      chk("rnd_ctl", act_ctl(), exp_ctl(cur, r_mr, r_z));
`ifdef MC_PERF_CNT_EN
      chk("rnd_cnt", {cyc_cnt, instr_cnt}, {32'(m_cyc), 32'(m_ins)});
`endif
      m_step(r_rst, r_op, r_mr);
      f_cnt = mfault ? f_cnt + 1 : 0;
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
